// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer for the E stage: models mult/div latency with a busy
// counter and commits a precomputed shadow result to HI/LO. Optional madd/msub under MD_MADD_EN.
module md_sequencer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_lat;
  logic [63:0]      r_shadow, w_res;
  logic [31:0]      r_hi, r_lo;
  logic             w_idle_start, w_long, w_is_div, w_commit;

  // Arithmetic datapath; the signed product is taken as the low 64 bits of sign-extended operands.
  logic [63:0] w_sext_rs, w_sext_rt, w_sprod, w_uprod;
  logic [31:0] w_rs_mag, w_rt_mag, w_sq_mag, w_sr_mag, w_sq, w_sr, w_uq, w_ur;
  logic        w_div0;

  assign w_sext_rs = {{32{rs_val[31]}}, rs_val};
  assign w_sext_rt = {{32{rt_val[31]}}, rt_val};
  assign w_sprod   = w_sext_rs * w_sext_rt;
  assign w_uprod   = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide via magnitudes, which also yields 0x80000000 / -1 = 0x80000000 rem 0.
  assign w_rs_mag = rs_val[31] ? -rs_val : rs_val;
  assign w_rt_mag = rt_val[31] ? -rt_val : rt_val;
  assign w_sq_mag = w_rs_mag / w_rt_mag;
  assign w_sr_mag = w_rs_mag % w_rt_mag;
  assign w_sq     = (rs_val[31] ^ rt_val[31]) ? -w_sq_mag : w_sq_mag;
  assign w_sr     = rs_val[31] ? -w_sr_mag : w_sr_mag;
  assign w_uq     = rs_val / rt_val;
  assign w_ur     = rs_val % rt_val;
  assign w_div0   = (rt_val == 32'd0);

  always_comb begin
    w_long   = 1'b0;
    w_is_div = 1'b0;
    w_res    = '0;
    case (md_op)
      OP_MULT:  begin w_long = 1'b1; w_res = w_sprod; end
      OP_MULTU: begin w_long = 1'b1; w_res = w_uprod; end
      OP_DIV:   begin
        w_long = 1'b1; w_is_div = 1'b1;
        w_res  = w_div0 ? {rs_val, 32'hFFFF_FFFF} : {w_sr, w_sq};
      end
      OP_DIVU:  begin
        w_long = 1'b1; w_is_div = 1'b1;
        w_res  = w_div0 ? {rs_val, 32'hFFFF_FFFF} : {w_ur, w_uq};
      end
`ifdef MD_MADD_EN
      OP_MADD:  begin w_long = 1'b1; w_res = {r_hi, r_lo} + w_sprod; end
      OP_MSUB:  begin w_long = 1'b1; w_res = {r_hi, r_lo} - w_sprod; end
`endif
      default:  ;
    endcase
  end

  assign w_lat        = w_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  assign w_idle_start = start && (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: if (w_idle_start && w_long) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = w_lat;
      end
      S_RUN: if (r_cnt == CNT_W'(1)) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_commit    = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_idle_start && w_long) r_shadow <= w_res;
      if (w_commit) {r_hi, r_lo} <= r_shadow;
      else if (w_idle_start && md_op == OP_MTHI) r_hi <= rs_val;
      else if (w_idle_start && md_op == OP_MTLO) r_lo <= rs_val;
    end
  end

  assign busy     = (r_state == S_RUN);
  assign md_stall = d_is_md & (busy | (start & w_long));
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: expected HI/LO pushed to a scoreboard at issue, popped at commit.
module tb_md_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, d_is_md;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val, hi, lo;
  logic        busy, md_stall;

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] sbq[$];

  md_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .d_is_md(d_is_md),
    .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issue one op with d_is_md held; count busy and stall cycles, then compare committed HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] exp);
    int nb, ns;
    logic [63:0] e;
    sbq.push_back(exp);
    d_is_md = 1'b1; start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    #1 ns = int'(md_stall);
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    #1 nb = 0;
    while (busy && nb < 40) begin
      nb++;
      ns += int'(md_stall);
      @(posedge clk); #2;
    end
    ns += int'(md_stall);
    chk({tag, "_busy"}, 64'(nb), 64'(lat));
    chk({tag, "_stall"}, 64'(ns), (lat > 0) ? 64'(lat + 1) : 64'd0);
    e = sbq.pop_front();
    chk({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    int nb;
    logic [31:0] a, b;
    logic [3:0] op;
    reset = 1'b0; start = 1'b0; d_is_md = 1'b0; md_op = 4'd0; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; d_is_md = 1'b1;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(md_stall), 64'd0);

    run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 64'h0000_0002_FFFF_FFFA);
    run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 64'h0000_0007_FFFF_FFFF);
    run_op("div0",  4'd3, 32'hFFFF_FFF9, 32'd0, 10, 64'hFFFF_FFF9_FFFF_FFFF);
    run_op("div7n2", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 64'h0000_0001_FFFF_FFFD);
    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000);
    run_op("mthi",  4'd5, 32'h1234_5678, 32'd0, 0, 64'h1234_5678_8000_0000);
    run_op("mtlo",  4'd6, 32'hAABB_CCDD, 32'd0, 0, 64'h1234_5678_AABB_CCDD);
    run_op("nop",   4'd0, 32'hDEAD_BEEF, 32'd1, 0, 64'h1234_5678_AABB_CCDD);

    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      op = 4'(1 + (i % 4));
      if (i == 6) b = 32'(i);
      run_op($sformatf("rnd%0d", i), op, a, b, (op >= 4'd3) ? 10 : 5, model(op, a, b));
    end

    // Commands presented while busy must be ignored.
    sbq.push_back(64'd30);
    start = 1'b1; md_op = 4'd1; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    nb = int'(busy);
    @(posedge clk); #1;
    nb += int'(busy);
    start = 1'b1; md_op = 4'd1; rs_val = 32'd100; rt_val = 32'd100;
    @(posedge clk); #1;
    nb += int'(busy);
    md_op = 4'd5;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    while (busy && nb < 40) begin nb++; @(posedge clk); #1; end
    chk("ign_busy", 64'(nb), 64'd5);
    chk("ign_hilo", {hi, lo}, sbq.pop_front());

    // Reset during busy cycle 3 of a div aborts it.
    start = 1'b1; md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_late_hilo", {hi, lo}, 64'd0);
    chk("abort_late_busy", 64'(busy), 64'd0);

`ifdef MD_MADD_EN
    run_op("m_mthi", 4'd5, 32'd0, 32'd0, 0, 64'h0000_0000_0000_0000);
    run_op("m_mtlo", 4'd6, 32'hFFFF_FFFF, 32'd0, 0, 64'h0000_0000_FFFF_FFFF);
    run_op("madd",   4'd7, 32'd1, 32'd1, 5, 64'h0000_0001_0000_0000);
    run_op("msub",   4'd8, 32'd2, 32'd3, 5, 64'h0000_0000_FFFF_FFFA);
`else
    run_op("op7", 4'd7, 32'd1, 32'd1, 0, 64'd0);
    run_op("op8", 4'd8, 32'd1, 32'd1, 0, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequencing controller for the HI/LO multiply/divide resource of the pipelined MIPS core. Sits in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and models the multi-cycle latency with a busy counter. Commits results to the HI/LO registers.
- Produces the stall request that holds a D-stage HI/LO-class instruction (mult/div/mfhi/mflo/mthi/mtlo) while the unit is occupied.
- The M-stage result-select `MD` source reads `hi`/`lo` from this block.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (>=1).
- DIV_LAT, 10, busy cycles for div/divu (>=1).
- CNT_W, 4, counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  E-stage instruction valid and HI/LO-writing this cycle.
- md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 msub (7/8 optional).
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- d_is_md  input  1  D-stage instruction is any HI/LO-class op.
- busy  output  1  multi-cycle operation in flight.
- md_stall  output  1  stall request to the hazard unit.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (reset==0 at a clk edge): hi=0, lo=0, busy=0, counter=0, pending result discarded.
  - Reset mid-operation aborts the operation; hi/lo do not receive its result.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counting down).
- Accept: start=1 in IDLE at cycle T.
  - mult/multu/div/divu: operands are latched and the 64-bit result is computed into a shadow register at the T edge. Go to RUN with counter=LAT.
  - busy=1 in cycles T+1..T+LAT.
  - Counter decrements every cycle in RUN. When it reaches 1, the next edge copies shadow->hi/lo and returns to IDLE.
  - New hi/lo values are visible in cycle T+LAT+1, the same cycle busy first reads 0.
  - mthi/mtlo: hi (or lo) = rs_val at the T edge, visible at T+1. No busy; the other register is unchanged.
- start=1 while busy: protocol violation (the hazard unit prevents it). The command is ignored and state is unchanged.
- md_op=0 with start=1: no effect.
- Arithmetic:
  - mult: signed 32x32->64.
  - multu: unsigned 32x32->64.
  - {hi,lo} = product.
  - div: lo=quotient, truncated toward zero; hi=remainder, taking the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divisor 0 (div and divu): lo=32'hFFFFFFFF, hi=rs_val.
  - div 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- md_stall = d_is_md & (busy | (start & md_op in {1,2,3,4,7,8})). Purely combinational.
  - mfhi/mflo in D therefore wait until committed values are visible.
- hi/lo are register outputs. No combinational path from the operands to hi/lo.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: md_op 7 (madd) and 8 (msub) are accepted, with latency MULT_LAT.
  - madd: {hi,lo} = {hi,lo} + signed(rs*rt).
  - msub: {hi,lo} = {hi,lo} - signed(rs*rt).
  - Accumulation uses the hi/lo values current at the accept edge. Wrap modulo 2^64.
- Undefined: md_op 7 and 8 are treated as 0 (no effect, no busy, no stall contribution).

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> hi=0, lo=0, busy=0, md_stall=0.
- mult with rs=32'hFFFFFFFE (-2), rt=3 -> busy for exactly 5 cycles; after that hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
  - multu with the same operands -> hi=2, lo=32'hFFFFFFFA.
- div with rs=-7 (32'hFFFFFFF9), rt=2 -> after 10 busy cycles lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - divu with rs=7, rt=0 -> lo=32'hFFFFFFFF, hi=7.
- d_is_md=1 held from the start cycle of a mult -> md_stall=1 for the start cycle plus 5 busy cycles (6 cycles total); md_stall drops in the cycle the new hi/lo are visible.
- mthi with rs=32'h12345678 while idle -> hi updates the next cycle, lo unchanged, busy never asserts.
  - start=1 with mult issued while busy -> ignored; the in-flight result is committed unchanged.
- reset pulsed at busy cycle 3 of a div -> hi=lo=0, busy=0 the next cycle, and the aborted result never appears.
  - With MD_MADD_EN: hi=0, lo=32'hFFFFFFFF, then madd with rs=1, rt=1 -> hi=1, lo=0.
